// File: rtl/sent_pkg.sv
// Shared constants, period-type and FSM encodings for the SENT transmit pulse generator.
package sent_pkg;

    localparam int unsigned LOW_TICKS         = 5;
    localparam int unsigned SYNC_TICKS        = 56;
    localparam int unsigned NIBBLE_BASE_TICKS = 12;
    localparam int unsigned PAUSE_TICKS_DEF   = 20;

    typedef enum logic [1:0] {
        PT_SYNC  = 2'd0,
        PT_PULSE = 2'd1,
        PT_PAUSE = 2'd2
    } ptype_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_e;

    // Period length in ticks for a captured period type and nibble.
    function automatic logic [9:0] period_len(
        input ptype_e     pt,
        input logic [3:0] nib,
        input logic [9:0] sync_ticks,
        input logic [9:0] pause_ticks,
        input logic [9:0] base_ticks
    );
        logic [9:0] len;
        case (pt)
            PT_SYNC:  len = sync_ticks;
            PT_PAUSE: len = pause_ticks;
            default:  len = base_ticks + {6'd0, nib};
        endcase
        return len;
    endfunction

endpackage

// File: rtl/sent_tick_prescaler.sv
// Divides clk by CLK_PER_TICK; tick marks the last clk of each tick, tick_early the one before.
import sent_pkg::*;

module sent_tick_prescaler #(
    parameter int unsigned CLK_PER_TICK = 4
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    output logic tick,
    output logic tick_early
);

    localparam logic [9:0] CNT_LAST  = 10'(CLK_PER_TICK - 1);
    localparam logic [9:0] CNT_EARLY = 10'(CLK_PER_TICK - 2);

    logic [9:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 10'd1;
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign tick       = en && (cnt_q == CNT_LAST);
    assign tick_early = en && (cnt_q == CNT_EARLY);

endmodule

// File: rtl/sent_tx_pulse_gen.sv
// SENT physical-layer period generator: turns level requests into tick-timed low/high periods
// and flags the last clk of each completed period on pulse_done.
import sent_pkg::*;

module sent_tx_pulse_gen #(
    parameter int unsigned CLK_PER_TICK      = 4,
    parameter int unsigned LOW_TICKS         = sent_pkg::LOW_TICKS,
    parameter int unsigned SYNC_TICKS        = sent_pkg::SYNC_TICKS,
    parameter int unsigned NIBBLE_BASE_TICKS = sent_pkg::NIBBLE_BASE_TICKS,
    parameter int unsigned PAUSE_TICKS       = sent_pkg::PAUSE_TICKS_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sync,
    input  logic       pulse,
    input  logic       pause,
    input  logic [3:0] data_nibble,
    output logic       sent_out,
    output logic       pulse_done,
    output logic       busy,
    output logic       tick
);

    localparam logic [9:0] LOW_LAST = 10'(LOW_TICKS - 1);

    state_e     state_q, state_d;
    ptype_e     ptype_q, ptype_d;
    logic [3:0] nibble_q, nibble_d;
    logic [9:0] tick_cnt_q, tick_cnt_d;
    logic       sent_out_q, sent_out_d;
    logic       pulse_done_q, pulse_done_d;

    logic       req, start, tick_early;
    logic [9:0] len_last;

    assign req  = sync | pulse | pause;
    assign busy = (state_q != ST_IDLE);

    sent_tick_prescaler #(
        .CLK_PER_TICK(CLK_PER_TICK)
    ) u_prescaler (
        .clk       (clk),
        .clr       (reset | start),
        .en        (busy),
        .tick      (tick),
        .tick_early(tick_early)
    );

    assign len_last = period_len(ptype_q, nibble_q, 10'(SYNC_TICKS), 10'(PAUSE_TICKS),
                                 10'(NIBBLE_BASE_TICKS)) - 10'd1;

    always_comb begin
        state_d      = state_q;
        ptype_d      = ptype_q;
        nibble_d     = nibble_q;
        sent_out_d   = sent_out_q;
        pulse_done_d = 1'b0;
        start        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                sent_out_d = 1'b1;
                if (req) begin
                    state_d    = ST_LOW;
                    sent_out_d = 1'b0;
                    start      = 1'b1;
                end
            end
            ST_LOW: begin
                // Late sample point gives the controller time to update after pulse_done.
                if (tick && tick_cnt_q == LOW_LAST) begin
                    sent_out_d = 1'b1;
                    if (req) begin
                        state_d  = ST_HIGH;
                        ptype_d  = sync ? PT_SYNC : (pause ? PT_PAUSE : PT_PULSE);
                        nibble_d = data_nibble;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_HIGH: begin
                // Registered pulse_done is armed one clk ahead so it lands on the final clk.
                if (tick_early && tick_cnt_q == len_last)
                    pulse_done_d = 1'b1;
                if (tick && tick_cnt_q == len_last) begin
                    if (req) begin
                        state_d    = ST_LOW;
                        sent_out_d = 1'b0;
                        start      = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                sent_out_d = 1'b1;
            end
        endcase
    end

    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (start)
            tick_cnt_d = '0;
        else if (tick)
            tick_cnt_d = tick_cnt_q + 10'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ptype_q      <= PT_PULSE;
            nibble_q     <= '0;
            tick_cnt_q   <= '0;
            sent_out_q   <= 1'b1;
            pulse_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptype_q      <= ptype_d;
            nibble_q     <= nibble_d;
            tick_cnt_q   <= tick_cnt_d;
            sent_out_q   <= sent_out_d;
            pulse_done_q <= pulse_done_d;
        end
    end

    assign sent_out   = sent_out_q;
    assign pulse_done = pulse_done_q;

endmodule

// File: tb/tb_sent_tx_pulse_gen.sv
// Directed checks of SENT period lengths, priority, abort, back-to-back and reset behaviour.
module tb_sent_tx_pulse_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sync = 1'b0, pulse = 1'b0, pause = 1'b0;
    logic [3:0] data_nibble = 4'd0;
    logic       sent_out, pulse_done, busy, tick;

    int errs = 0;
    int checks = 0;

    sent_tx_pulse_gen dut (
        .clk        (clk),
        .reset      (reset),
        .sync       (sync),
        .pulse      (pulse),
        .pause      (pause),
        .data_nibble(data_nibble),
        .sent_out   (sent_out),
        .pulse_done (pulse_done),
        .busy       (busy),
        .tick       (tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts at clk index 'start' of a period; returns low-phase length, period length
    // (clks up to and including the pulse_done clk), tick count and whether busy held.
    task automatic measure(input int start, input logic [3:0] late_nib,
                           output int low, output int per, output int ticks,
                           output int busy_ok);
        int k;
        k = start;
        ticks = 0;
        busy_ok = 1;
        while (sent_out === 1'b0 && k < 2000) begin
            if (tick === 1'b1) ticks++;
            if (busy !== 1'b1) busy_ok = 0;
            k++;
            step();
        end
        low = k;
        data_nibble = late_nib;
        while (pulse_done !== 1'b1 && k < 2000) begin
            if (tick === 1'b1) ticks++;
            if (busy !== 1'b1) busy_ok = 0;
            k++;
            step();
        end
        if (tick === 1'b1) ticks++;
        per = k + 1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_out"}, int'(sent_out), 1);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(pulse_done), 0);
    endtask

    initial begin
        int low, per, ticks, bok, pd_seen;

        repeat (3) step();
        chk_idle("rst");
        chk("rst_tick", int'(tick), 0);
        reset = 1'b0;
        step();
        chk_idle("post_rst");

        // Single nibble-0 pulse
        pulse = 1'b1; data_nibble = 4'h0;
        step();
        chk("p0_fall", int'(sent_out), 0);
        measure(0, 4'h0, low, per, ticks, bok);
        chk("p0_low", low, 20);
        chk("p0_per", per, 48);
        chk("p0_ticks", ticks, 12);
        chk("p0_busy", bok, 1);
        pulse = 1'b0;
        step();
        chk_idle("p0_end");
        repeat (3) step();

        // 0xF back-to-back with 0x3
        pulse = 1'b1; data_nibble = 4'hF;
        step();
        measure(0, 4'hF, low, per, ticks, bok);
        chk("pf_per", per, 108);
        step();
        chk("b2b_nogap", int'(sent_out), 0);
        chk("b2b_done1", int'(pulse_done), 0);
        step();
        data_nibble = 4'h3;
        measure(1, 4'h3, low, per, ticks, bok);
        chk("p3_low", low, 20);
        chk("p3_per", per, 60);
        pulse = 1'b0;
        step();
        chk_idle("p3_end");

        // Sync wins over pulse
        sync = 1'b1; pulse = 1'b1; data_nibble = 4'h0;
        step();
        measure(0, 4'h0, low, per, ticks, bok);
        chk("sync_low", low, 20);
        chk("sync_per", per, 224);
        chk("sync_ticks", ticks, 56);
        sync = 1'b0; pulse = 1'b0;
        step();
        chk_idle("sync_end");

        // Pause alone, then pause+pulse back-to-back
        pause = 1'b1;
        step();
        measure(0, 4'h0, low, per, ticks, bok);
        chk("pause_per", per, 80);
        pulse = 1'b1;
        step();
        measure(0, 4'h0, low, per, ticks, bok);
        chk("pause_prio_per", per, 80);
        pause = 1'b0; pulse = 1'b0;
        step();
        chk_idle("pause_end");

        // Nibble changed after the sample point is ignored
        pulse = 1'b1; data_nibble = 4'h5;
        step();
        measure(0, 4'hF, low, per, ticks, bok);
        chk("late_nib_per", per, 68);
        pulse = 1'b0;
        step();
        chk_idle("late_end");

        // Abort: request dropped mid-LOW
        pulse = 1'b1; data_nibble = 4'h0;
        step();
        repeat (10) step();
        pulse = 1'b0;
        pd_seen = 0;
        repeat (9) begin
            step();
            if (pulse_done === 1'b1) pd_seen = 1;
        end
        chk("abort_low19", int'(sent_out), 0);
        step();
        chk("abort_out", int'(sent_out), 1);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", pd_seen | int'(pulse_done), 0);
        repeat (3) step();

        // Reset mid-HIGH of a 0x7 nibble, then a fresh exact period
        pulse = 1'b1; data_nibble = 4'h7;
        step();
        repeat (40) step();
        chk("pre_rst_high", int'(sent_out), 1);
        reset = 1'b1; pulse = 1'b0;
        step();
        chk_idle("midrst");
        reset = 1'b0;
        step();
        chk_idle("midrst_rel");
        pulse = 1'b1;
        step();
        chk("p7_fall", int'(sent_out), 0);
        measure(0, 4'h7, low, per, ticks, bok);
        chk("p7_low", low, 20);
        chk("p7_per", per, 76);
        pulse = 1'b0;
        step();
        chk_idle("p7_end");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/sent_tx_pulse_gen.md
Name: sent_tx_pulse_gen

Overview:
- Physical-layer stage of the SENT transmitter, directly downstream of the transmit control FSM.
- Converts level requests (sync / pulse+nibble / pause) and a 4-bit nibble into tick-timed SENT periods on a single open-drain-style output line.
- Reports completion of each period through pulse_done; the control FSM detects the falling edge of pulse_done.
- Output line idles high. Every period starts with a falling edge, holds a fixed low phase, then stays high until the period ends.

Parameters:
CLK_PER_TICK, 4, clock cycles per SENT tick; legal range 4..1023.
LOW_TICKS, 5, ticks of the low phase at the start of every period.
SYNC_TICKS, 56, total ticks of a sync/calibration period.
NIBBLE_BASE_TICKS, 12, ticks of a nibble period with value 0; period length = NIBBLE_BASE_TICKS + value.
PAUSE_TICKS, 20, total ticks of a pause period; legal range 12..768.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
sync  input  1  level request: emit sync periods
pulse  input  1  level request: emit nibble periods
pause  input  1  level request: emit pause periods
data_nibble  input  4  nibble value for a pulse period
sent_out  output  1  SENT line, idle high
pulse_done  output  1  high for exactly one clk on the last clk of each completed period
busy  output  1  high while a period is in progress
tick  output  1  one-clk strobe at every tick boundary while busy; diagnostic

Behaviour:
- Reset is synchronous, active-high, on clk only.
  - Reset values: sent_out=1, pulse_done=0, busy=0, tick=0.
  - All counters are cleared and the FSM goes to IDLE.
  - Reset asserted mid-period aborts the period immediately. The line returns high on the next clk and pulse_done is not produced.
- FSM states: IDLE, LOW, HIGH.
- IDLE:
  - sent_out=1.
  - If any request (sync|pulse|pause) is high, go to LOW next clk with the tick counter at 0. sent_out falls on that same edge.
- LOW:
  - sent_out=0 for LOW_TICKS*CLK_PER_TICK clks.
  - Period type and nibble are sampled on the last clk of LOW, with priority sync > pause > pulse.
  - The captured nibble is held in a register for the rest of the period; later data_nibble changes are ignored.
  - The period length in ticks is computed:
    - sync: SYNC_TICKS
    - pause: PAUSE_TICKS
    - pulse: NIBBLE_BASE_TICKS + nibble, zero-extended to 10 bits
  - If no request is high at the sample point, the period is abandoned: go to IDLE, sent_out=1, no pulse_done.
- HIGH:
  - sent_out=1 until total ticks elapsed equals the period length.
  - On the final clk of the period, pulse_done=1 for one clk.
  - Next state on the following clk:
    - If any request is high, go to LOW, giving a back-to-back period with no gap.
    - Otherwise go to IDLE.
- Handshake timing:
  - The controller sees the falling edge of pulse_done one clk after the period ends and updates its requests and nibble within 2 clks.
  - Late sampling at the end of LOW (≥20 clks later) guarantees the new values are used.
  - This is why CLK_PER_TICK ≥ 4 is required.
- Counters:
  - Clock prescaler counts 0..CLK_PER_TICK-1; its wrap produces tick.
  - Tick counter is 10 bits and counts ticks within the period.
- Lengths are exact: a nibble value v gives a period of exactly (12+v)*CLK_PER_TICK clks, measured from falling edge to falling edge.
- Simultaneous requests are resolved by the priority rule only. Requests that drop before the sample point take no effect beyond the already-started low phase.
- busy=1 in LOW and HIGH, 0 in IDLE.

Decomposition:
- Shared package sent_pkg holds:
  - tick constants: LOW_TICKS, SYNC_TICKS, NIBBLE_BASE_TICKS
  - the period-type enum: PT_SYNC, PT_PULSE, PT_PAUSE
  - the FSM state encoding
- One sub-module, sent_tick_prescaler: CLK_PER_TICK divider with a synchronous clear and a one-clk tick output.
- The FSM and the period length compare stay in the top module.

Test Plan:
- Single pulse: pulse=1 with data_nibble=0 held for one period, then pulse=0 → 20 clks low, 28 clks high, pulse_done at clk 48, then IDLE with sent_out=1.
- Nibble 0xF back-to-back with 0x3: controller changes data_nibble 2 clks after pulse_done → periods of 108 clks and 60 clks, no idle gap, each period followed by one pulse_done.
- Sync: sync=1 → 224-clk period (20 low, 204 high), pulse_done at clk 224; with pulse=1 also high, the period is still a sync period.
- Pause: pause=1, PAUSE_TICKS=20 → 80-clk period; pause and pulse together → pause wins.
- Abort: pulse deasserted at clk 10 of LOW → line high at clk 20, no pulse_done, busy=0.
- Reset mid-HIGH of a 0x7 nibble (reset at clk 40) → sent_out=1 and busy=0 one clk later; a fresh pulse request afterwards produces an exact 76-clk period.
